// File: rtl/c7bifu_issue_ctl.sv
// c7bifu decode-stage issue sequencing: stall/flush generation, LSU serialisation, serial drain.
// Optional LSU watchdog built when C7BIFU_ISSUE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module c7bifu_issue_ctl #(
    parameter int DRAIN_CYC   = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dec_inst_vld_d,
    input  logic       dec_lsu_d,
    input  logic       dec_serial_d,
    input  logic [4:0] dec_rd_d,
    input  logic       dec_wen_d,
    input  logic       exu_lsu_done,
    input  logic       exu_lsu_exc,
    input  logic       exu_bru_redirect,
    input  logic       exu_exc_commit,
    output logic       stall,
    output logic       flush,
    output logic [4:0] lsu_rd,
    output logic       lsu_wen,
    output logic       lsu_timeout,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LSU_BUSY = 2'd1,
        ST_SERIAL   = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

    generate
        if (DRAIN_CYC < 1 || DRAIN_CYC > 15) begin : g_bad_drain
            $error("c7bifu_issue_ctl: DRAIN_CYC out of range 1..15");
        end
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
            $error("c7bifu_issue_ctl: TIMEOUT_CYC out of range 1..255");
        end
    endgenerate

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_drain_cnt;
    logic [3:0] w_drain_cnt_nxt;
    logic       r_flush;
    logic       w_flush_nxt;
    logic [4:0] r_lsu_rd;
    logic [4:0] w_lsu_rd_nxt;
    logic       r_lsu_wen;
    logic       w_lsu_wen_nxt;
    logic       w_issue;
    logic       w_kill;
    logic       w_timeout;

    // Stall is a pure decode of registered state: no input reaches it combinationally.
    assign stall     = (r_state != ST_IDLE);
    assign flush     = r_flush;
    assign lsu_rd    = r_lsu_rd;
    assign lsu_wen   = r_lsu_wen;
    assign dbg_state = r_state;

    assign w_issue = dec_inst_vld_d & ~stall;
    assign w_kill  = exu_bru_redirect | exu_exc_commit | exu_lsu_exc | w_timeout;

`ifdef C7BIFU_ISSUE_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYC);

    logic [7:0] r_wdog;
    logic [7:0] w_wdog_nxt;

    assign w_timeout   = (r_state == ST_LSU_BUSY) && (r_wdog == WDOG_LIMIT);
    assign lsu_timeout = w_timeout;

    // Zero on entry to LSU_BUSY (and whenever idle), count while the LSU stays busy.
    always_comb begin
        w_wdog_nxt = 8'd0;
        if (r_state == ST_LSU_BUSY && w_state_nxt == ST_LSU_BUSY) begin
            w_wdog_nxt = r_wdog + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= 8'd0;
        end else begin
            r_wdog <= w_wdog_nxt;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign lsu_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_flush_nxt     = 1'b0;
        w_lsu_rd_nxt    = r_lsu_rd;
        w_lsu_wen_nxt   = r_lsu_wen;

        if (w_kill) begin
            w_state_nxt     = ST_IDLE;
            w_flush_nxt     = 1'b1;
            w_lsu_wen_nxt   = 1'b0;
            w_drain_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue && dec_lsu_d) begin
                        w_state_nxt   = ST_LSU_BUSY;
                        w_lsu_rd_nxt  = dec_rd_d;
                        w_lsu_wen_nxt = dec_wen_d & (dec_rd_d != 5'd0);
                    end else if (w_issue && dec_serial_d) begin
                        w_state_nxt     = ST_SERIAL;
                        w_drain_cnt_nxt = DRAIN_LOAD;
                    end
                end
                ST_LSU_BUSY: begin
                    // lsu_rd is kept after completion; only the write enable drops.
                    if (exu_lsu_done) begin
                        w_state_nxt   = ST_IDLE;
                        w_lsu_wen_nxt = 1'b0;
                    end
                end
                ST_SERIAL: begin
                    if (r_drain_cnt == 4'd0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= 4'd0;
            r_flush     <= 1'b0;
            r_lsu_rd    <= 5'd0;
            r_lsu_wen   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_flush     <= w_flush_nxt;
            r_lsu_rd    <= w_lsu_rd_nxt;
            r_lsu_wen   <= w_lsu_wen_nxt;
        end
    end

endmodule

// File: doc/c7bifu_issue_ctl.md
# c7bifu_issue_ctl

Issue sequencing controller for the c7bifu decode stage. It generates the decoder's `stall` and `flush` inputs and serialises long-latency and serialising instructions. LSU operations issue alone. CSR, ERTN and exception-class instructions drain for a fixed number of cycles. EXU redirects and exceptions flush the front end. It also latches the destination of the outstanding LSU operation for the EXU execution control logic.

## Interface
Parameters:
- `DRAIN_CYC`, default 3, serialising drain length in cycles; legal range 1..15.
- `TIMEOUT_CYC`, default 255, LSU watchdog limit in cycles; legal range 1..255. Used only with `C7BIFU_ISSUE_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `dec_inst_vld_d`  in  1  decode-stage instruction valid, before stall gating.
- `dec_lsu_d`  in  1  decoded instruction is LSU class (raw class, not gated by valid).
- `dec_serial_d`  in  1  decoded instruction is CSR, TLB, cache, ERTN or exception class.
- `dec_rd_d`  in  5  destination register of the decoded instruction.
- `dec_wen_d`  in  1  decoded instruction writes the GPR file.
- `exu_lsu_done`  in  1  outstanding LSU operation completed this cycle.
- `exu_lsu_exc`  in  1  outstanding LSU operation faulted this cycle.
- `exu_bru_redirect`  in  1  taken branch or jump resolved in EXU.
- `exu_exc_commit`  in  1  exception or ERTN committed in EXU.
- `stall`  out  1  to decoder; blocks issue.
- `flush`  out  1  to decoder and EXU; kills younger instructions.
- `lsu_rd`  out  5  latched destination register of the outstanding LSU operation.
- `lsu_wen`  out  1  the outstanding LSU operation writes `lsu_rd`.
- `lsu_timeout`  out  1  watchdog expiry pulse.

## Operation
- States: IDLE, LSU_BUSY, SERIAL.
- `issue = dec_inst_vld_d & ~stall`.
- `stall = (state != IDLE)`. It is decoded from registered state only, so there is no combinational path from any input to `stall`.
- Kill event: `exu_bru_redirect | exu_exc_commit | exu_lsu_exc`.
- On a kill event:
  - next state is IDLE, regardless of the current state.
  - `flush` is registered high for exactly the next cycle.
  - `lsu_wen` is cleared.
  - the drain counter is cleared.
- Otherwise, transitions by state:
  - IDLE, `issue & dec_lsu_d`: go to LSU_BUSY; latch `lsu_rd <= dec_rd_d` and `lsu_wen <= dec_wen_d & (dec_rd_d != 0)`.
  - IDLE, `issue & dec_serial_d & ~dec_lsu_d`: go to SERIAL; load drain counter with DRAIN_CYC-1.
  - IDLE, any other issue: stay in IDLE.
  - LSU_BUSY, `exu_lsu_done`: go to IDLE; clear `lsu_wen` on the same edge. `lsu_rd` holds its value.
  - SERIAL: decrement the counter each cycle; go to IDLE on the edge where the counter is 0.
- Priority: reset > kill event > `exu_lsu_done` > issue.
- `exu_lsu_done` or `exu_lsu_exc` while in IDLE or SERIAL is ignored, except that `exu_lsu_exc` still acts as a kill event.
- `flush` asserted while `dec_inst_vld_d` is high does not issue. `stall` is low in that cycle, but the decoder drops the instruction. This block still treats it as an issue unless a kill event occurs in the same cycle. The EXU must never return a stale completion for such an instruction.

## Timing
- Reset values: `stall=0`, `flush=0`, `lsu_rd=0`, `lsu_wen=0`, `lsu_timeout=0`, state IDLE, both counters 0.
- Reset asserted mid-operation returns every output and counter to its reset value on the next edge.
- `stall` rises in the cycle after an LSU or serialising issue.
- LSU: `stall` falls in the cycle after `exu_lsu_done`.
- SERIAL: `stall` stays high for exactly DRAIN_CYC cycles.
- `flush` is high in the cycle after a kill event and lasts one cycle. `stall` is low in that cycle.
- Back-to-back: an LSU can issue in the cycle `stall` falls.

## Configuration
- `C7BIFU_ISSUE_TIMEOUT_EN` defined:
  - an 8-bit watchdog counter clears on entry to LSU_BUSY and increments each cycle while in LSU_BUSY.
  - when the counter reaches TIMEOUT_CYC, `lsu_timeout` pulses for one cycle.
  - that expiry is treated as a kill event (flush, go to IDLE, clear `lsu_wen`).
- `C7BIFU_ISSUE_TIMEOUT_EN` undefined: no counter is built, `lsu_timeout` is tied to 0, and LSU_BUSY waits indefinitely.

## Test plan
- Reset sequence, then an LSU issue with `dec_rd_d=5`, `dec_wen_d=1`, and `exu_lsu_done` 4 cycles later: `stall` high for 4 cycles, `lsu_rd=5`, `lsu_wen=1` until done, then `lsu_wen=0`.
- LSU issue with `dec_rd_d=0`, `dec_wen_d=1` -> `lsu_wen=0` and `lsu_rd=0`.
- CSR issue with DRAIN_CYC=3 -> `stall` high for exactly 3 cycles; a following ALU instruction issues in the 4th cycle.
- `exu_lsu_done` and `exu_bru_redirect` in the same cycle during LSU_BUSY -> kill wins: `flush=1` for one cycle, state IDLE, `lsu_wen=0`.
- SERIAL with counter at 2 and `exu_exc_commit` -> `flush` the next cycle, `stall=0`, counter 0.
- Timeout macro enabled, TIMEOUT_CYC=10, no done after an LSU issue -> `lsu_timeout` and then `flush` pulse; with the macro disabled, `stall` stays high after 300 cycles.
